// File: rtl/cs_address_sequencer_pkg.sv
// Shared definitions for the control-store address sequencer and the condition branch logic.
package cs_address_sequencer_pkg;

  typedef enum logic [1:0] {
    SEL_NEXT   = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_DECODE = 2'b10,
    SEL_RETURN = 2'b11
  } csas_sel_e;

  localparam int unsigned CSAS_RESET_VECTOR = 0;
  localparam logic        CSAS_DECODE_PREFIX = 1'b1;

endpackage

// File: rtl/cs_address_sequencer_cs_return_stack.sv
// Microcode subroutine return stack: storage, pointer, full/empty, sticky overflow/underflow.
module cs_return_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_push_addr,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [SP_W-1:0]  r_sp;
  logic [AW-1:0]    r_mem [DEPTH];
  logic             r_ovf;
  logic             r_unf;
  logic             w_full;
  logic             w_empty;
  logic [SP_W-1:0]  w_sp_dec;
  logic [IDX_W-1:0] w_top_idx;

  assign w_full    = (r_sp == SP_W'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_sp_dec  = r_sp - 1'b1;
  assign w_top_idx = w_sp_dec[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (i_push) begin
      if (w_full) r_ovf <= 1'b1;
      else        r_sp  <= r_sp + 1'b1;
    end else if (i_pop) begin
      if (w_empty) r_unf <= 1'b1;
      else         r_sp  <= w_sp_dec;
    end
  end

  // Storage carries no reset; only entries below SP are ever read as valid.
  always_ff @(posedge clk) begin
    if (i_push && !w_full) r_mem[r_sp[IDX_W-1:0]] <= i_push_addr;
  end

  assign o_top   = r_mem[w_top_idx];
  assign o_empty = w_empty;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer: next-address mux and address register.
// Optional return stack enabled by defining CSAS_RETURN_STACK_EN.
module cs_address_sequencer
  import cs_address_sequencer_pkg::*;
#(
  parameter int CS_ADDR_WIDTH   = 11,
  parameter int DECODE_OP_WIDTH = 8,
  parameter int RSTACK_DEPTH    = 4
) (
  input  logic                       CSAS_CLOCK_50,
  input  logic                       CSAS_RESET_InLow,
  input  logic [1:0]                 CSAS_SEL_IN,
  input  logic [CS_ADDR_WIDTH-1:0]   CSAS_JADDR_IN,
  input  logic                       CSAS_LINK_IN,
  input  logic [DECODE_OP_WIDTH-1:0] CSAS_IROP_IN,
  input  logic                       CSAS_STALL_IN,
  output logic [CS_ADDR_WIDTH-1:0]   CSAS_ADDR_OUT,
  output logic                       CSAS_OVF_OUT,
  output logic                       CSAS_UNF_OUT
);

  localparam int DEC_W = DECODE_OP_WIDTH + 3;

  logic [CS_ADDR_WIDTH-1:0] r_addr;
  logic [CS_ADDR_WIDTH-1:0] w_addr_nxt;
  logic [CS_ADDR_WIDTH-1:0] w_next;
  logic [CS_ADDR_WIDTH-1:0] w_decode;
  logic [CS_ADDR_WIDTH-1:0] w_reset_vec;
  logic [DEC_W-1:0]         w_decode_full;
  csas_sel_e                w_sel;

  assign w_sel         = csas_sel_e'(CSAS_SEL_IN);
  assign w_next        = r_addr + 1'b1;
  assign w_decode_full = {CSAS_DECODE_PREFIX, CSAS_IROP_IN, 2'b00};
  assign w_decode      = CS_ADDR_WIDTH'(w_decode_full);
  assign w_reset_vec   = CS_ADDR_WIDTH'(CSAS_RESET_VECTOR);

`ifdef CSAS_RETURN_STACK_EN
  logic [CS_ADDR_WIDTH-1:0] w_top;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;

  // Stall gates the stack so pointer and flags hold with the address.
  assign w_push = !CSAS_STALL_IN && (w_sel == SEL_JUMP) && CSAS_LINK_IN;
  assign w_pop  = !CSAS_STALL_IN && (w_sel == SEL_RETURN);

  cs_return_stack #(
    .DEPTH (RSTACK_DEPTH),
    .AW    (CS_ADDR_WIDTH)
  ) u_rstack (
    .clk         (CSAS_CLOCK_50),
    .rst_n       (CSAS_RESET_InLow),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_addr (w_next),
    .o_top       (w_top),
    .o_empty     (w_empty),
    .o_ovf       (CSAS_OVF_OUT),
    .o_unf       (CSAS_UNF_OUT)
  );
`else
  logic w_unused_link;
  localparam int unused_rstack_depth = RSTACK_DEPTH;

  assign w_unused_link = CSAS_LINK_IN;
  assign CSAS_OVF_OUT  = 1'b0;
  assign CSAS_UNF_OUT  = 1'b0;
`endif

  always_comb begin
    w_addr_nxt = w_next;
    case (w_sel)
      SEL_NEXT:   w_addr_nxt = w_next;
      SEL_JUMP:   w_addr_nxt = CSAS_JADDR_IN;
      SEL_DECODE: w_addr_nxt = w_decode;
`ifdef CSAS_RETURN_STACK_EN
      SEL_RETURN: w_addr_nxt = w_empty ? w_reset_vec : w_top;
`else
      SEL_RETURN: w_addr_nxt = w_next;
`endif
      default:    w_addr_nxt = w_next;
    endcase
  end

  always_ff @(posedge CSAS_CLOCK_50 or negedge CSAS_RESET_InLow) begin
    if (!CSAS_RESET_InLow)   r_addr <= w_reset_vec;
    else if (!CSAS_STALL_IN) r_addr <= w_addr_nxt;
  end

  assign CSAS_ADDR_OUT = r_addr;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed self-checking bench for cs_address_sequencer (both CSAS_RETURN_STACK_EN builds).
module tb_cs_address_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [10:0] jaddr;
  logic        link;
  logic [7:0]  irop;
  logic        stall;
  logic [10:0] addr;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  cs_address_sequencer #(
    .CS_ADDR_WIDTH   (11),
    .DECODE_OP_WIDTH (8),
    .RSTACK_DEPTH    (4)
  ) dut (
    .CSAS_CLOCK_50    (clk),
    .CSAS_RESET_InLow (rst_n),
    .CSAS_SEL_IN      (sel),
    .CSAS_JADDR_IN    (jaddr),
    .CSAS_LINK_IN     (link),
    .CSAS_IROP_IN     (irop),
    .CSAS_STALL_IN    (stall),
    .CSAS_ADDR_OUT    (addr),
    .CSAS_OVF_OUT     (ovf),
    .CSAS_UNF_OUT     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [10:0] j, input logic l);
    sel   = s;
    jaddr = j;
    link  = l;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 2'b00;
    jaddr = '0;
    link  = 1'b0;
    irop  = '0;
    stall = 1'b0;

    tick();
    tick();
    chk("reset_addr", 32'(addr), 32'h0);
    chk("reset_ovf",  32'(ovf),  32'h0);
    chk("reset_unf",  32'(unf),  32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("next_1", 32'(addr), 32'h1);
    tick(); chk("next_2", 32'(addr), 32'h2);
    tick(); chk("next_3", 32'(addr), 32'h3);
    tick();
    tick(); chk("next_5", 32'(addr), 32'h5);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_addr", 32'(addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("after_reset_next", 32'(addr), 32'h1);

    drive(2'b01, 11'h7FF, 1'b0);
    tick(); chk("jump_7ff", 32'(addr), 32'h7FF);
    drive(2'b00, 11'h000, 1'b0);
    tick(); chk("wrap_to_0", 32'(addr), 32'h0);

    drive(2'b01, 11'h1A5, 1'b0);
    tick(); chk("jump_1a5", 32'(addr), 32'h1A5);

    irop = 8'b10_010000;
    drive(2'b10, 11'h000, 1'b0);
    tick(); chk("decode_addcc", 32'(addr), 32'h640);

    stall = 1'b1;
    drive(2'b01, 11'h300, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("stall_hold", 32'(addr), 32'h640);
    end
    stall = 1'b0;
    tick(); chk("stall_release", 32'(addr), 32'h300);

`ifdef CSAS_RETURN_STACK_EN
    drive(2'b01, 11'h010, 1'b0);
    tick(); chk("goto_010", 32'(addr), 32'h010);
    drive(2'b01, 11'h200, 1'b1);
    tick(); chk("call_200", 32'(addr), 32'h200);
    drive(2'b00, 11'h000, 1'b1);
    tick(); chk("sub_next1", 32'(addr), 32'h201);
    tick(); chk("sub_next2", 32'(addr), 32'h202);
    drive(2'b11, 11'h000, 1'b1);
    tick(); chk("return_011", 32'(addr), 32'h011);
    chk("return_ovf", 32'(ovf), 32'h0);
    chk("return_unf", 32'(unf), 32'h0);

    // Pushed return addresses: 0x012, 0x101, 0x102, 0x103; fifth overflows
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 11'(11'h100 + i), 1'b1);
      tick();
      chk("linked_jump_addr", 32'(addr), 32'h100 + i);
      chk("linked_jump_ovf", 32'(ovf), (i == 4) ? 32'h1 : 32'h0);
    end
    drive(2'b11, 11'h000, 1'b0);
    tick(); chk("pop_after_ovf", 32'(addr), 32'h103);
    stall = 1'b1;
    tick(); chk("stall_pop_hold1", 32'(addr), 32'h103);
    tick(); chk("stall_pop_hold2", 32'(addr), 32'h103);
    stall = 1'b0;
    tick(); chk("pop_2", 32'(addr), 32'h102);
    chk("ovf_sticky", 32'(ovf), 32'h1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_clears_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 11'h000, 1'b0);
    tick(); chk("underflow_addr", 32'(addr), 32'h0);
    chk("underflow_unf", 32'(unf), 32'h1);
    drive(2'b00, 11'h000, 1'b0);
    tick(); chk("unf_sticky_addr", 32'(addr), 32'h1);
    chk("unf_sticky", 32'(unf), 32'h1);
`else
    drive(2'b01, 11'h050, 1'b0);
    tick(); chk("goto_050", 32'(addr), 32'h050);
    drive(2'b11, 11'h000, 1'b1);
    tick(); chk("sel11_as_next", 32'(addr), 32'h051);
    drive(2'b01, 11'h100, 1'b1);
    tick(); chk("link_jump_100", 32'(addr), 32'h100);
    drive(2'b11, 11'h000, 1'b0);
    tick(); chk("sel11_no_return", 32'(addr), 32'h101);
    chk("off_ovf", 32'(ovf), 32'h0);
    chk("off_unf", 32'(unf), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
